instr_prefetch_queue: RTL and testbench

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

---
 rtl/instr_prefetch_queue.sv | 161 ++++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch_queue
// Brief    : Ring of prefetched instructions between instruction memory and
//            decode; flushes and drops stale responses on a redirect.
// Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_en,
    input  logic [XLEN-1:0]            redirect_addr,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    output logic                       id_valid,
    output logic [31:0]                id_instr,
    output logic [XLEN-1:0]            id_pc,
    input  logic                       id_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned     c_PTR_W      = $clog2(DEPTH);
    localparam int unsigned     c_CNT_W      = $clog2(DEPTH + 1);
    localparam int unsigned     c_OCC_W      = c_CNT_W + 2;
    localparam logic [31:0]     c_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] c_PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] c_RESET_PC   = RESET_PC & c_ALIGN_MASK;

    // Control state
    logic [XLEN-1:0]    fetch_pc_q,  fetch_pc_d;
    logic [c_PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [c_PTR_W-1:0] fill_ptr_q,  fill_ptr_d;
    logic [c_PTR_W-1:0] head_ptr_q,  head_ptr_d;
    logic [c_CNT_W-1:0] res_cnt_q,   res_cnt_d;
    logic [c_CNT_W-1:0] fil_cnt_q,   fil_cnt_d;
    logic [c_CNT_W-1:0] drop_cnt_q,  drop_cnt_d;
    logic [DEPTH-1:0]   filled_q,    filled_d;

    // Slot payload
    logic [XLEN-1:0]    pc_q    [DEPTH];
    logic [XLEN-1:0]    pc_d    [DEPTH];
    logic [31:0]        instr_q [DEPTH];
    logic [31:0]        instr_d [DEPTH];

    logic [c_OCC_W-1:0] w_occ;
    logic [c_CNT_W-1:0] w_pending;
    logic               w_grant;
    logic               w_fill;
    logic               w_drop;
    logic               w_pop;
    logic               w_retire;

    // Every issued request owns either a reserved slot or a drop credit,
    // so the sum below is the true occupancy seen by the memory side.
    always_comb begin
        w_occ     = c_OCC_W'(res_cnt_q) + c_OCC_W'(fil_cnt_q) + c_OCC_W'(drop_cnt_q);
        w_pending = drop_cnt_q + res_cnt_q;
        imem_req  = ~reset & ~redirect_en & (w_occ < c_OCC_W'(DEPTH));
        imem_addr = fetch_pc_q;
        w_grant   = imem_req & imem_gnt;
        w_drop    = imem_rvalid & (drop_cnt_q != '0);
        w_fill    = imem_rvalid & (drop_cnt_q == '0) & (res_cnt_q != '0);
        w_retire  = imem_rvalid & (w_pending != '0);
    end

    always_comb begin
        id_valid = filled_q[head_ptr_q];
        id_instr = c_NOP;
        id_pc    = '0;
        if (id_valid) begin
            id_instr = instr_q[head_ptr_q];
            id_pc    = pc_q[head_ptr_q];
        end
        w_pop = id_valid & id_ready;
        count = fil_cnt_q;
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        res_cnt_d   = res_cnt_q;
        fil_cnt_d   = fil_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        filled_d    = filled_q;
        pc_d        = pc_q;
        instr_d     = instr_q;

        if (redirect_en) begin
            // In-flight requests become drop credits; a response arriving
            // this very cycle retires one of them immediately.
            fetch_pc_d  = redirect_addr & c_ALIGN_MASK;
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            res_cnt_d   = '0;
            fil_cnt_d   = '0;
            filled_d    = '0;
            drop_cnt_d  = w_pending - c_CNT_W'(w_retire);
        end else begin
            if (w_grant) begin
                pc_d[alloc_ptr_q] = fetch_pc_q;
                alloc_ptr_d       = alloc_ptr_q + 1'b1;
                fetch_pc_d        = fetch_pc_q + c_PC_STEP;
            end
            if (w_drop) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (w_fill) begin
                instr_d[fill_ptr_q]  = imem_rdata;
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = fill_ptr_q + 1'b1;
            end
            if (w_pop) begin
                filled_d[head_ptr_q] = 1'b0;
                head_ptr_d           = head_ptr_q + 1'b1;
            end
            res_cnt_d = res_cnt_q + c_CNT_W'(w_grant) - c_CNT_W'(w_fill);
            fil_cnt_d = fil_cnt_q + c_CNT_W'(w_fill) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q  <= c_RESET_PC;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            res_cnt_q   <= '0;
            fil_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            filled_q    <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            res_cnt_q   <= res_cnt_d;
            fil_cnt_q   <= fil_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            filled_q    <= filled_d;
        end
    end

    // Payload is qualified by filled_q, so it needs no reset.
    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        instr_q <= instr_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_prefetch_queue
// Brief    : Directed tables and random traffic for instr_prefetch_queue,
//            checked against a queue-based model of fetch and decode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_queue;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0080;
    localparam logic [31:0] c_NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_en;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic [2:0]  count;

    always #5 clk = ~clk;

    instr_prefetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_ready      (id_ready),
        .count         (count)
    );

    // Model: requests issued to memory (with a still-wanted flag) and the
    // instructions that have arrived and wait for decode, oldest first.
    logic [31:0] pend_addr [$];
    bit          pend_live [$];
    logic [31:0] rdy_pc    [$];
    logic [31:0] rdy_instr [$];
    logic [31:0] m_pc;
    bit          illegal_ok;

    int unsigned n_vec;
    int unsigned n_err;

    typedef struct {
        logic [31:0] raddr;
        logic [31:0] exp_pc0;
        logic [31:0] exp_pc1;
    } redir_vec_t;

    redir_vec_t tbl [3];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hDEAD_BEEF;
    endfunction

    function automatic bit m_req();
        return !reset && !redirect_en && ((pend_addr.size() + rdy_pc.size()) < DEPTH);
    endfunction

    function automatic void model_reset();
        pend_addr.delete();
        pend_live.delete();
        rdy_pc.delete();
        rdy_instr.delete();
        m_pc = RESET_PC;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        bit v;
        v = rdy_pc.size() > 0;
        chk("imem_req", 64'(imem_req), 64'(m_req()));
        chk("imem_addr", 64'(imem_addr), 64'(m_pc));
        chk("id_valid", 64'(id_valid), 64'(v));
        chk("id_pc", 64'(id_pc), v ? 64'(rdy_pc[0]) : 64'h0);
        chk("id_instr", 64'(id_instr), v ? 64'(rdy_instr[0]) : 64'(c_NOP));
        chk("count", 64'(count), 64'(rdy_pc.size()));
    endtask

    task automatic advance();
        bit          grant;
        bit          pop;
        bit          live;
        logic [31:0] a;
        if (reset) return;
        grant = m_req() && imem_gnt;
        pop   = (rdy_pc.size() > 0) && id_ready;
        live  = 1'b0;
        a     = '0;
        if (imem_rvalid && pend_addr.size() > 0) begin
            a    = pend_addr.pop_front();
            live = pend_live.pop_front();
        end
        if (redirect_en) begin
            rdy_pc.delete();
            rdy_instr.delete();
            foreach (pend_live[i]) pend_live[i] = 1'b0;
            m_pc = {redirect_addr[31:2], 2'b00};
        end else begin
            if (pop) begin
                void'(rdy_pc.pop_front());
                void'(rdy_instr.pop_front());
            end
            if (live) begin
                rdy_pc.push_back(a);
                rdy_instr.push_back(imem_rdata);
            end
            if (grant) begin
                pend_addr.push_back(m_pc);
                pend_live.push_back(1'b1);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // rv: 0 = no response, 1 = respond if anything is outstanding,
    // 2 = deliberately illegal response with nothing outstanding.
    task automatic cycle(input bit rst_i, input bit redir, input logic [31:0] raddr,
                         input bit gnt, input int rv, input bit rdy);
        bit rv_b;
        @(negedge clk);
        rv_b = !rst_i && ((rv == 2) || (rv == 1 && pend_addr.size() > 0));
        if (rst_i) model_reset();
        reset         = rst_i;
        redirect_en   = redir;
        redirect_addr = raddr;
        imem_gnt      = gnt;
        id_ready      = rdy;
        imem_rvalid   = rv_b;
        illegal_ok    = (rv == 2);
        imem_rdata    = (rv_b && pend_addr.size() > 0) ? instr_of(pend_addr[0]) : $urandom();
        assert (illegal_ok || !imem_rvalid || pend_addr.size() > 0)
            else $error("rvalid driven with no outstanding request");
        #1;
        compare_all();
        advance();
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 0, 1'b0);
    endtask

    task automatic run_until_valid(input bit gnt, input bit rdy, input int max_cyc, output int n);
        n = 0;
        do begin
            cycle(1'b0, 1'b0, 32'h0, gnt, 1, rdy);
            n++;
        end while (!id_valid && n < max_cyc);
        if (!id_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_valid: id_valid=%0b after %0d cycles, required 1", id_valid, max_cyc);
        end
    endtask

    initial begin
        int n;
        int r;
        logic [31:0] ra;

        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        redirect_en = 1'b0;
        redirect_addr = '0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        id_ready = 1'b0;
        illegal_ok = 1'b0;
        model_reset();

        tbl[0] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[1] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
        tbl[2] = '{32'h7FFF_FFFE, 32'h7FFF_FFFC, 32'h8000_0000};

        // Reset values
        do_reset();
        chk("rst_req", 64'(imem_req), 64'h0);
        chk("rst_valid", 64'(id_valid), 64'h0);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_instr", 64'(id_instr), 64'(c_NOP));
        chk("rst_pc", 64'(id_pc), 64'h0);
        chk("rst_addr", 64'(imem_addr), 64'(RESET_PC));

        // Streaming: one instruction per cycle after a two-cycle startup
        for (int k = 0; k < 12; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1);
            if (k == 0) chk("stream_first_req", 64'(imem_req), 64'h1);
            if (k >= 2) begin
                chk("stream_valid", 64'(id_valid), 64'h1);
                chk("stream_pc", 64'(id_pc), 64'(RESET_PC + 32'(4 * (k - 2))));
            end
        end

        // Backpressure: queue fills, requests stop, order kept on release
        do_reset();
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
        chk("bp_count", 64'(count), 64'(DEPTH));
        chk("bp_req", 64'(imem_req), 64'h0);
        chk("bp_head", 64'(id_pc), 64'(RESET_PC));
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1);

        // Redirect with three requests outstanding
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b1);
        cycle(1'b0, 1'b1, 32'h100, 1'b1, 0, 1'b1);
        run_until_valid(1'b1, 1'b1, 20, n);
        chk("r3_latency", 64'(n), 64'd5);
        chk("r3_pc", 64'(id_pc), 64'h100);

        // Redirect coinciding with a response, two unfilled
        do_reset();
        for (int k = 0; k < 2; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b1);
        cycle(1'b0, 1'b1, 32'h100, 1'b1, 1, 1'b1);
        run_until_valid(1'b1, 1'b1, 20, n);
        chk("r2rv_latency", 64'(n), 64'd3);
        chk("r2rv_pc", 64'(id_pc), 64'h100);

        // Redirect target table: alignment and address wrap
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
            cycle(1'b0, 1'b1, tbl[i].raddr, 1'($urandom_range(0, 1)), 1, 1'b0);
            run_until_valid(1'b1, 1'b1, 20, n);
            chk("tbl_pc0", 64'(id_pc), 64'(tbl[i].exp_pc0));
            chk("tbl_instr0", 64'(id_instr), 64'(instr_of(tbl[i].exp_pc0)));
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1);
            chk("tbl_valid1", 64'(id_valid), 64'h1);
            chk("tbl_pc1", 64'(id_pc), 64'(tbl[i].exp_pc1));
        end

        // Stray response with nothing outstanding is ignored
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 2, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b1);
        chk("illegal_count", 64'(count), 64'h0);
        chk("illegal_valid", 64'(id_valid), 64'h0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1);

        // Asynchronous reset between edges with a full queue
        do_reset();
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
        chk("ar_full", 64'(count), 64'(DEPTH));
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 0, 1'b0);
        chk("ar_req", 64'(imem_req), 64'h0);
        chk("ar_valid", 64'(id_valid), 64'h0);
        chk("ar_count", 64'(count), 64'h0);
        chk("ar_instr", 64'(id_instr), 64'(c_NOP));
        chk("ar_pc", 64'(id_pc), 64'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b1);
        chk("ar_first_req", 64'(imem_req), 64'h1);
        chk("ar_first_addr", 64'(imem_addr), 64'(RESET_PC));

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            r  = int'($urandom_range(0, 99));
            ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            if (k % 700 == 699) begin
                cycle(1'b1, 1'b0, 32'h0, 1'b0, 0, 1'b0);
            end else begin
                cycle(1'b0, r < 6, ra, $urandom_range(0, 3) != 0,
                      ($urandom_range(0, 2) != 0) ? 1 : 0, $urandom_range(0, 9) < 7);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
